// File: rtl/wisard_pkg.sv
// Shared definitions for the wisard core and its sample streamer.
package wisard_pkg;

    localparam int unsigned DEF_ADDRESS_WIDTH = 16;
    localparam int unsigned DEF_INDEX_WIDTH   = 8;
    localparam int unsigned SAMPLE_CNT_W      = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_GAP    = 2'd2
    } stream_state_e;

endpackage

// File: rtl/wisard_sample_bank.sv
// Ping-pong sample storage: two banks of N_WORDS address words, one write port
// and one combinational read port. Contents are deliberately left unreset.
module wisard_sample_bank #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned N_WORDS = 196,
    parameter int unsigned IDX_W   = 8
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic              wbank_i,
    input  logic [IDX_W-1:0]  widx_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              rbank_i,
    input  logic [IDX_W-1:0]  ridx_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [2][N_WORDS];

    // Storage write port
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[wbank_i][widx_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rbank_i][ridx_i];

endmodule

// File: rtl/wisard_sample_streamer.sv
// Buffers whole samples from a loader into two banks and replays each one as a
// sop/sink_valid/eop/addr/index burst of N_RAMS beats toward the wisard core.
module wisard_sample_streamer
    import wisard_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
    parameter int unsigned INDEX_WIDTH   = DEF_INDEX_WIDTH,
    parameter int unsigned N_RAMS        = 196,
    parameter int unsigned GAP_CYCLES    = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_valid,
    input  logic [ADDRESS_WIDTH-1:0] wr_data,
    input  logic                     wr_last,
    output logic                     wr_ready,
    output logic                     sop,
    output logic                     sink_valid,
    output logic                     eop,
    output logic [ADDRESS_WIDTH-1:0] addr,
    output logic [INDEX_WIDTH-1:0]   index,
    output logic                     busy,
    output logic                     proto_err,
    output logic [SAMPLE_CNT_W-1:0]  samples_sent
);

    localparam int unsigned BANK_IDX_W = (N_RAMS > 1) ? $clog2(N_RAMS) : 1;
    localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(N_RAMS - 1);
    localparam logic [7:0] GAP_LAST = 8'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

    if (N_RAMS == 0 || N_RAMS > (2 ** INDEX_WIDTH) || GAP_CYCLES > 255) begin : g_bad_cfg
        $error("wisard_sample_streamer: N_RAMS must fit INDEX_WIDTH and GAP_CYCLES must be 0..255");
    end

    stream_state_e                state_q, state_d;
    logic [1:0]                   full_q, full_d;
    logic                         wr_bank_q, wr_bank_d;
    logic                         rd_bank_q, rd_bank_d;
    logic [INDEX_WIDTH-1:0]       wr_idx_q, wr_idx_d;
    logic [7:0]                   gap_cnt_q, gap_cnt_d;
    logic                         sop_q, sop_d;
    logic                         valid_q, valid_d;
    logic                         eop_q, eop_d;
    logic [ADDRESS_WIDTH-1:0]     addr_q, addr_d;
    logic [INDEX_WIDTH-1:0]       index_q, index_d;
    logic                         proto_err_q, proto_err_d;
    logic [SAMPLE_CNT_W-1:0]      samples_q, samples_d;

    logic                         accept_s;
    logic                         release_s;
    logic                         we_s;
    logic                         start_s;
    logic                         rbank_s;
    logic [INDEX_WIDTH-1:0]       ridx_s;
    logic [ADDRESS_WIDTH-1:0]     rdata_s;

    wisard_sample_bank #(
        .DATA_W  (ADDRESS_WIDTH),
        .N_WORDS (N_RAMS),
        .IDX_W   (BANK_IDX_W)
    ) u_bank (
        .clk     (clk),
        .we_i    (we_s),
        .wbank_i (wr_bank_q),
        .widx_i  (wr_idx_q[BANK_IDX_W-1:0]),
        .wdata_i (wr_data),
        .rbank_i (rbank_s),
        .ridx_i  (ridx_s[BANK_IDX_W-1:0]),
        .rdata_o (rdata_s)
    );

    assign accept_s  = wr_valid && !full_q[wr_bank_q];
    assign release_s = (state_q == ST_STREAM) && eop_q;

    // Loader side: word acceptance, commit/drop and bank ownership flags
    always_comb begin
        full_d      = full_q;
        wr_bank_d   = wr_bank_q;
        wr_idx_d    = wr_idx_q;
        we_s        = 1'b0;
        proto_err_d = 1'b0;
        if (accept_s) begin
            if (wr_idx_q == LAST_IDX) begin
                we_s              = 1'b1;
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
                wr_idx_d          = '0;
                proto_err_d       = ~wr_last;
            end else if (wr_last) begin
                wr_idx_d    = '0;
                proto_err_d = 1'b1;
            end else begin
                we_s     = 1'b1;
                wr_idx_d = wr_idx_q + INDEX_WIDTH'(1);
            end
        end else begin
            we_s = 1'b0;
        end
        // Commit and release always target different banks, so both apply.
        if (release_s) begin
            full_d[rd_bank_q] = 1'b0;
        end else begin
            full_d[rd_bank_q] = full_d[rd_bank_q];
        end
    end

    // Burst FSM: next state and next values of the registered stream outputs
    always_comb begin
        state_d   = state_q;
        rd_bank_d = rd_bank_q;
        gap_cnt_d = gap_cnt_q;
        samples_d = samples_q;
        sop_d     = 1'b0;
        valid_d   = 1'b0;
        eop_d     = 1'b0;
        addr_d    = '0;
        index_d   = '0;
        rbank_s   = rd_bank_q;
        ridx_s    = '0;
        start_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (full_q[rd_bank_q]) begin
                    start_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_STREAM: begin
                if (eop_q) begin
                    rd_bank_d = ~rd_bank_q;
                    samples_d = samples_q + SAMPLE_CNT_W'(1);
                    if (GAP_CYCLES == 0 && full_q[~rd_bank_q]) begin
                        start_s = 1'b1;
                        rbank_s = ~rd_bank_q;
                    end else if (GAP_CYCLES != 0) begin
                        state_d   = ST_GAP;
                        gap_cnt_d = GAP_LAST;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    ridx_s  = index_q + INDEX_WIDTH'(1);
                    valid_d = 1'b1;
                    index_d = ridx_s;
                    addr_d  = rdata_s;
                    eop_d   = (ridx_s == LAST_IDX);
                end
            end
            ST_GAP: begin
                // The last gap cycle doubles as the IDLE decision so the idle
                // stretch is exactly GAP_CYCLES long.
                if (gap_cnt_q != 8'd0) begin
                    gap_cnt_d = gap_cnt_q - 8'd1;
                end else if (full_q[rd_bank_q]) begin
                    start_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (start_s) begin
            state_d = ST_STREAM;
            sop_d   = 1'b1;
            valid_d = 1'b1;
            eop_d   = (LAST_IDX == '0);
            addr_d  = rdata_s;
            index_d = '0;
        end else begin
            sop_d = 1'b0;
        end
    end

    // State, pointer and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            full_q      <= 2'b00;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            wr_idx_q    <= '0;
            gap_cnt_q   <= 8'd0;
            sop_q       <= 1'b0;
            valid_q     <= 1'b0;
            eop_q       <= 1'b0;
            addr_q      <= '0;
            index_q     <= '0;
            proto_err_q <= 1'b0;
            samples_q   <= '0;
        end else begin
            state_q     <= state_d;
            full_q      <= full_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            wr_idx_q    <= wr_idx_d;
            gap_cnt_q   <= gap_cnt_d;
            sop_q       <= sop_d;
            valid_q     <= valid_d;
            eop_q       <= eop_d;
            addr_q      <= addr_d;
            index_q     <= index_d;
            proto_err_q <= proto_err_d;
            samples_q   <= samples_d;
        end
    end

    assign wr_ready     = !full_q[wr_bank_q];
    assign busy         = (state_q != ST_IDLE) || (|full_q);
    assign sop          = sop_q;
    assign sink_valid   = valid_q;
    assign eop          = eop_q;
    assign addr         = addr_q;
    assign index        = index_q;
    assign proto_err    = proto_err_q;
    assign samples_sent = samples_q;

endmodule

// File: tb/tb_wisard_sample_streamer.sv
// Scoreboard bench for wisard_sample_streamer (N_RAMS=4): back-to-back instance
// plus a GAP_CYCLES=3 instance for idle-gap timing.
module tb_wisard_sample_streamer;
    import wisard_pkg::*;

    localparam int AW = 16;
    localparam int IW = 8;
    localparam int NR = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          wr_valid = 1'b0, wr_last = 1'b0;
    logic [AW-1:0] wr_data = '0;
    logic          wr_ready, sop, sink_valid, eop, busy, proto_err;
    logic [AW-1:0] addr;
    logic [IW-1:0] index;
    logic [15:0]   samples_sent;

    logic          g_wr_valid = 1'b0, g_wr_last = 1'b0;
    logic [AW-1:0] g_wr_data = '0;
    logic          g_wr_ready, g_sop, g_sink_valid, g_eop, g_busy, g_proto_err;
    logic [AW-1:0] g_addr;
    logic [IW-1:0] g_index;
    logic [15:0]   g_samples_sent;

    wisard_sample_streamer #(.ADDRESS_WIDTH(AW), .INDEX_WIDTH(IW), .N_RAMS(NR), .GAP_CYCLES(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_data(wr_data), .wr_last(wr_last),
        .wr_ready(wr_ready), .sop(sop), .sink_valid(sink_valid), .eop(eop), .addr(addr),
        .index(index), .busy(busy), .proto_err(proto_err), .samples_sent(samples_sent)
    );

    wisard_sample_streamer #(.ADDRESS_WIDTH(AW), .INDEX_WIDTH(IW), .N_RAMS(NR), .GAP_CYCLES(3)) u_dut_gap (
        .clk(clk), .rst_n(rst_n), .wr_valid(g_wr_valid), .wr_data(g_wr_data), .wr_last(g_wr_last),
        .wr_ready(g_wr_ready), .sop(g_sop), .sink_valid(g_sink_valid), .eop(g_eop), .addr(g_addr),
        .index(g_index), .busy(g_busy), .proto_err(g_proto_err), .samples_sent(g_samples_sent)
    );

    typedef struct packed {
        logic          sop;
        logic          eop;
        logic [AW-1:0] addr;
        logic [IW-1:0] index;
    } beat_t;

    beat_t exp_q[$];
    int n_checks = 0;
    int n_errors = 0;
    int run_len  = 0;
    int last_run = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: every valid beat is popped from the scoreboard and compared
    initial begin : monitor
        beat_t got;
        beat_t want;
        forever begin
            @(negedge clk);
            if (rst_n && sink_valid === 1'b1) begin
                run_len++;
                got = {sop, eop, addr, index};
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 32'(sink_valid), 32'd0);
                end else begin
                    want = exp_q.pop_front();
                    chk("beat", 32'(got), 32'(want));
                end
            end else begin
                if (run_len != 0) last_run = run_len;
                run_len = 0;
            end
        end
    end

    task automatic push_word(input logic [AW-1:0] d, input logic last, input logic exp_perr);
        int waits = 0;
        wr_valid = 1'b1;
        wr_data  = d;
        wr_last  = last;
        while (wr_ready !== 1'b1 && waits < 100) begin
            @(negedge clk);
            waits++;
        end
        if (waits >= 100) chk("wr_ready_wait", 32'(waits), 32'd0);
        @(negedge clk);
        chk("proto_err", 32'(proto_err), 32'(exp_perr));
        wr_valid = 1'b0;
        wr_last  = 1'b0;
    endtask

    task automatic load_sample(input logic [AW-1:0] base, input logic mark_last);
        beat_t b;
        for (int i = 0; i < NR; i++)
            push_word(base + AW'(i), (i == NR - 1) && mark_last, (i == NR - 1) && !mark_last);
        for (int i = 0; i < NR; i++) begin
            b = {i == 0, i == NR - 1, base + AW'(i), IW'(i)};
            exp_q.push_back(b);
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int n;
        int zeros;
        repeat (3) @(negedge clk);
        chk("rst_sink_valid", 32'(sink_valid), 32'd0);
        chk("rst_sop_eop", 32'({sop, eop}), 32'd0);
        chk("rst_addr_index", 32'({addr, index}), 32'd0);
        chk("rst_busy_perr", 32'({busy, proto_err}), 32'd0);
        chk("rst_samples", 32'(samples_sent), 32'd0);
        chk("rst_wr_ready", 32'(wr_ready), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // Single sample A..D, sop one edge after commit
        load_sample(16'h000A, 1'b1);
        chk("latency_idle", 32'(sink_valid), 32'd0);
        @(negedge clk);
        chk("latency_sop", 32'(sop), 32'd1);
        wait_drain();
        chk("samples_1", 32'(samples_sent), 32'd1);

        // Two samples back to back: one contiguous 8-beat run
        load_sample(16'h0001, 1'b1);
        load_sample(16'h0005, 1'b1);
        wait_drain();
        chk("b2b_run_len", 32'(last_run), 32'd8);
        chk("samples_3", 32'(samples_sent), 32'd3);

        // Third sample while both banks are full
        load_sample(16'h0100, 1'b1);
        load_sample(16'h0200, 1'b1);
        chk("wr_ready_both_full", 32'(wr_ready), 32'd0);
        chk("busy_both_full", 32'(busy), 32'd1);
        load_sample(16'h0300, 1'b1);
        wait_drain();
        chk("samples_6", 32'(samples_sent), 32'd6);

        // Early wr_last drops the partial sample
        push_word(16'h0111, 1'b0, 1'b0);
        push_word(16'h0222, 1'b1, 1'b1);
        repeat (6) @(negedge clk);
        chk("drop_no_busy", 32'(busy), 32'd0);
        chk("drop_samples", 32'(samples_sent), 32'd6);
        // Missing wr_last still commits, with an error pulse
        load_sample(16'h0400, 1'b0);
        wait_drain();
        load_sample(16'h0500, 1'b1);
        wait_drain();
        chk("samples_8", 32'(samples_sent), 32'd8);

        // Reset in the middle of a burst
        load_sample(16'h0600, 1'b1);
        n = 0;
        while (!(sink_valid === 1'b1 && index == IW'(2)) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("reach_index2", 32'(index), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid_sop_eop", 32'({sink_valid, sop, eop}), 32'd0);
        chk("mid_rst_addr_index", 32'({addr, index}), 32'd0);
        chk("mid_rst_samples", 32'(samples_sent), 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("post_rst_wr_ready", 32'(wr_ready), 32'd1);
        chk("post_rst_busy", 32'(busy), 32'd0);
        load_sample(16'h0700, 1'b1);
        wait_drain();
        chk("post_rst_samples", 32'(samples_sent), 32'd1);

        // GAP_CYCLES=3 instance: two samples queued
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < NR; i++) begin
                g_wr_valid = 1'b1;
                g_wr_data  = AW'((s + 1) * 16'h0A00 + i);
                g_wr_last  = (i == NR - 1);
                chk("g_wr_ready", 32'(g_wr_ready), 32'd1);
                @(negedge clk);
            end
        end
        g_wr_valid = 1'b0;
        g_wr_last  = 1'b0;
        n = 0;
        while (g_eop !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("g_first_eop", 32'({g_eop, g_addr}), 32'({1'b1, 16'h0A03}));
        @(negedge clk);
        zeros = 0;
        n = 0;
        while (g_sop !== 1'b1 && n < 50) begin
            if (g_sink_valid !== 1'b1) zeros++;
            @(negedge clk);
            n++;
        end
        chk("g_idle_cycles", 32'(zeros), 32'd3);
        chk("g_second_sop", 32'({g_sop, g_sink_valid, g_addr, g_index}), 32'({2'b11, 16'h1400, 8'd0}));
        chk("g_samples_1", 32'(g_samples_sent), 32'd1);
        n = 0;
        while (g_busy === 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("g_samples_2", 32'(g_samples_sent), 32'd2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
